mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 15, maximum wait cycles for mem_ack_i when watchdog compiled in.
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req_i in 1, if_addr_i in ADDR_W: fetch request and PC.
REQ-007 SHALL have ports if_valid_o out 1, if_rdata_o out DATA_W: fetch completion and instruction.
REQ-008 SHALL have ports d_req_i in 1, d_we_i in 1, d_addr_i in ADDR_W, d_wdata_i in DATA_W: load/store request from MEM stage.
REQ-009 SHALL have ports d_valid_o out 1, d_rdata_o out DATA_W: data completion and load data.
REQ-010 SHALL have ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_W, mem_wdata_o out DATA_W, mem_rdata_i in DATA_W, mem_ack_i in 1: single shared memory port.
REQ-011 SHALL have ports stall_if_o out 1 (freeze PC, IF/ID) and stall_mem_o out 1 (freeze all pipe registers).
REQ-012 SHALL have port timeout_o out 1, sticky watchdog flag.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DATA.
REQ-014 In IDLE, with one request pending, SHALL go to that request's state next cycle; with none, SHALL stay IDLE.
REQ-015 In IDLE with both pending, SHALL pick DATA unless fetch_prio flag set, then FETCH.
REQ-016 fetch_prio SHALL set on DATA completion and clear on FETCH completion (anti-starvation).
REQ-017 On grant (IDLE exit) SHALL register address, we, wdata of the winner; mem_* outputs SHALL hold stable until ack.
REQ-018 mem_req_o SHALL be 1 exactly while state is FETCH or DATA; mem_we_o SHALL be 0 in FETCH.
REQ-019 On mem_ack_i in FETCH: if_valid_o=1 same cycle, if_rdata_o=mem_rdata_i combinationally, state->IDLE.
REQ-020 On mem_ack_i in DATA: d_valid_o=1 same cycle, d_rdata_o=mem_rdata_i (don't-care on store), state->IDLE.
REQ-021 Valid outputs SHALL be 0 in every other cycle; mem_ack_i in IDLE SHALL be ignored.
REQ-022 Minimum transaction latency: request in IDLE cycle N, ack earliest N+1, one IDLE cycle between transactions.
REQ-023 stall_if_o SHALL equal if_req_i AND NOT if_valid_o; stall_mem_o SHALL equal d_req_i AND NOT d_valid_o.
REQ-024 Requester SHALL hold req and payload stable until its valid; payload change before valid is a protocol error, not detected.

Reset
REQ-025 rst_i low SHALL asynchronously force state IDLE, fetch_prio 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, timeout_o 0, watchdog count 0.
REQ-026 Reset during FETCH/DATA SHALL abandon the transaction; no valid pulse issued for it; first grant earliest first edge after rst_i high.

Configuration
REQ-027 With MEM_ARB_TIMEOUT_EN defined: counter counts cycles in FETCH/DATA without ack, clears on state entry; at TIMEOUT_CYC it SHALL drop mem_req_o, go IDLE, pulse the owner's valid with rdata 32'h0000_0013 (fetch) or 0 (data), set timeout_o sticky until reset.
REQ-028 Without MEM_ARB_TIMEOUT_EN: no counter logic, timeout_o tied 0, FSM waits for ack indefinitely.

Structure
REQ-029 Package mem_arb_pkg SHALL hold state enum (IDLE/FETCH/DATA) and NOP constant 32'h0000_0013.
REQ-030 Watchdog SHALL be sub-module mem_arb_watchdog (counter, compare, expired pulse), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-031 Fetch only: if_req=1, addr 0x10, ack after 3 cycles with 0x00500093 -> if_valid one cycle, rdata 0x00500093, stall_if 1 for 4 cycles.
REQ-032 Simultaneous: both req, fetch_prio 0 -> DATA granted first (mem_addr=d_addr), then FETCH; after data done fetch_prio=1.
REQ-033 Alternation: both held through 4 transactions -> grant order DATA, FETCH, DATA, FETCH.
REQ-034 Store: d_we=1, addr 0x20, wdata 0xDEADBEEF -> mem_we=1, mem_wdata stable until ack; d_valid on ack cycle.
REQ-035 Reset mid-DATA: rst_i low 2 cycles before ack -> mem_req 0 immediately, no d_valid, clean re-grant after release.
REQ-036 With MEM_ARB_TIMEOUT_EN, no ack: after 15 wait cycles -> mem_req 0, if_valid with 0x00000013, timeout_o stays 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter: the arbiter FSM state
//   encoding, the NOP instruction returned on a fetch watchdog timeout, and
//   the IDLE arbitration decision.
//   Optional feature: the watchdog is compiled in only when the macro
//   MEM_ARB_TIMEOUT_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_e;

    // addi x0, x0, 0 -- returned as the instruction of a timed-out fetch
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Data normally wins a tie. Once a data access completes, the next tie
    // goes to fetch so that a busy load/store stream cannot starve fetch.
    function automatic logic pick_data(input logic d_req,
                                       input logic if_req,
                                       input logic fetch_prio);
        return d_req && !(if_req && fetch_prio);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Counts cycles that a granted memory transaction has waited without an
//   acknowledge. It raises expired_o during the TIMEOUT_CYC-th such cycle,
//   so the owner sees exactly TIMEOUT_CYC cycles of mem_req before the
//   arbiter gives up.
//   Ports:
//     clk_i, rst_i  clock, asynchronous active-low reset
//     busy_i        arbiter is in FETCH or DATA
//     ack_i         memory acknowledge
//     expired_o     wait budget exhausted this cycle (combinational)
//   Instantiated only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = busy_i && !ack_i && (cnt_q == LAST);

    // There is always at least one IDLE cycle between transactions, so
    // clearing while idle also clears on every FETCH/DATA entry.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i || ack_i || expired_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch and the MEM-stage
//   load/store requester. One transaction is in flight at a time; the
//   winner's address/we/wdata are captured at grant and held on mem_*
//   until the acknowledge. Completions are signalled combinationally in
//   the ack cycle.
//   Ports:
//     clk_i, rst_i                       clock, asynchronous active-low reset
//     if_req_i, if_addr_i                fetch request and PC
//     if_valid_o, if_rdata_o             fetch completion and instruction
//     d_req_i, d_we_i, d_addr_i,
//     d_wdata_i                          load/store request
//     d_valid_o, d_rdata_o               data completion and load data
//     mem_req_o, mem_we_o, mem_addr_o,
//     mem_wdata_o, mem_rdata_i,
//     mem_ack_i                          shared memory port
//     stall_if_o, stall_mem_o            pipeline freeze requests
//     timeout_o                          sticky watchdog flag
//   Optional feature: MEM_ARB_TIMEOUT_EN compiles in the ack watchdog.
//   Without it timeout_o is 0 and the FSM waits for the ack indefinitely.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              timeout_o
);

    arb_state_e        state_q, state_d;
    logic              fetch_prio_q, fetch_prio_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy;
    logic              expired;
    logic              done;

    assign busy = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout_q;

    mem_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .busy_i   (busy),
        .ack_i    (mem_ack_i),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            timeout_q <= 1'b0;
        end else if (expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign expired            = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // An ack in IDLE is ignored because busy gates it.
    assign done = busy && (mem_ack_i || expired);

    always_comb begin
        state_d      = state_q;
        fetch_prio_d = fetch_prio_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_data(d_req_i, if_req_i, fetch_prio_q)) begin
                    state_d = DATA;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    wdata_d = d_wdata_i;
                end else if (if_req_i) begin
                    state_d = FETCH;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            FETCH: begin
                if (done) begin
                    state_d      = IDLE;
                    fetch_prio_d = 1'b0;
                end
            end
            DATA: begin
                if (done) begin
                    state_d      = IDLE;
                    fetch_prio_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            fetch_prio_q <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_prio_q <= fetch_prio_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
        end
    end

    assign mem_req_o   = busy;
    assign mem_we_o    = we_q && (state_q == DATA);
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // A timed-out fetch returns a NOP so the pipeline keeps moving; a
    // timed-out load returns zero.
    assign if_valid_o  = (state_q == FETCH) && done;
    assign if_rdata_o  = expired ? DATA_W'(NOP_INSN) : mem_rdata_i;
    assign d_valid_o   = (state_q == DATA) && done;
    assign d_rdata_o   = expired ? '0 : mem_rdata_i;

    assign stall_if_o  = if_req_i && !if_valid_o;
    assign stall_mem_o = d_req_i && !d_valid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. Tests queue the expected grants
//   (address/we/wdata in grant order) and the expected completion data per
//   port; autonomous requester and memory-responder processes drive the
//   DUT, and a monitor on the falling edge pops and compares whenever the
//   DUT presents a grant or a valid.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_valid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_valid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_if_o;
    logic        stall_mem_o;
    logic        timeout_o;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(15)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } grant_t;
    typedef struct { int delay; logic [31:0] rdata; } resp_t;
    typedef struct { logic [31:0] rdata; bit chk; } dexp_t;

    logic [31:0] fq[$];
    grant_t      dq[$];
    logic [31:0] exp_f[$];
    dexp_t       exp_d[$];
    grant_t      gq[$];
    resp_t       rq[$];

    int     checks, errors;
    int     f_done_cnt, d_done_cnt;
    bit     f_active, d_active;
    int     stall_if_cnt, stall_mem_cnt, req_cyc;
    bit     in_txn;
    grant_t cur;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_grant(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        gq.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    task automatic respond(input int delay, input logic [31:0] rdata);
        rq.push_back('{delay: delay, rdata: rdata});
    endtask

    task automatic issue_fetch(input logic [31:0] addr, input logic [31:0] exp_rdata);
        fq.push_back(addr);
        exp_f.push_back(exp_rdata);
    endtask

    task automatic issue_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit chk);
        dq.push_back('{we: we, addr: addr, wdata: wdata});
        exp_d.push_back('{rdata: exp_rdata, chk: chk});
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk_i);
            if (!rst_i) in_txn = 0;
            if (stall_if_o)  stall_if_cnt++;
            if (stall_mem_o) stall_mem_cnt++;
            if (mem_req_o)   req_cyc++;
            if (mem_req_o) begin
                if (!in_txn) begin
                    in_txn = 1;
                    if (gq.size() == 0) begin
                        fail_now("unexpected grant");
                        cur = '{we: mem_we_o, addr: mem_addr_o, wdata: mem_wdata_o};
                    end else begin
                        cur = gq.pop_front();
                    end
                end
                chk32("mem_addr", mem_addr_o, cur.addr);
                chk32("mem_we", {31'b0, mem_we_o}, {31'b0, cur.we});
                if (cur.we) chk32("mem_wdata", mem_wdata_o, cur.wdata);
            end
            if (if_valid_o) begin
                f_done_cnt++;
                in_txn = 0;
                if (exp_f.size() == 0) fail_now("unexpected if_valid");
                else chk32("if_rdata", if_rdata_o, exp_f.pop_front());
            end
            if (d_valid_o) begin
                dexp_t e;
                d_done_cnt++;
                in_txn = 0;
                if (exp_d.size() == 0) begin
                    fail_now("unexpected d_valid");
                end else begin
                    e = exp_d.pop_front();
                    if (e.chk) chk32("d_rdata", d_rdata_o, e.rdata);
                end
            end
        end
    endtask

    // Holds each fetch request until its completion, then presents the next.
    task automatic fetch_req_loop();
        int seen = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (f_active && f_done_cnt != seen) begin
                seen     = f_done_cnt;
                f_active = 0;
            end
            if (!f_active && fq.size() > 0) begin
                if_addr_i = fq.pop_front();
                f_active  = 1;
            end
            if_req_i = f_active;
        end
    endtask

    task automatic data_req_loop();
        int     seen = 0;
        grant_t r;
        forever begin
            @(posedge clk_i);
            #1;
            if (d_active && d_done_cnt != seen) begin
                seen     = d_done_cnt;
                d_active = 0;
            end
            if (!d_active && dq.size() > 0) begin
                r         = dq.pop_front();
                d_we_i    = r.we;
                d_addr_i  = r.addr;
                d_wdata_i = r.wdata;
                d_active  = 1;
            end
            if (!d_active) d_we_i = 1'b0;
            d_req_i = d_active;
        end
    endtask

    // Acks the current transaction after rq[0].delay wait cycles; junk data otherwise.
    task automatic resp_loop();
        int cnt = 0;
        forever begin
            @(posedge clk_i);
            #2;
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_0000;
            if (!rst_i) begin
                rq.delete();
                cnt = 0;
            end else if (mem_req_o && rq.size() > 0) begin
                if (cnt == rq[0].delay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rq[0].rdata;
                    void'(rq.pop_front());
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (n < budget) begin
            @(negedge clk_i);
            #1;
            if (fq.size() == 0 && dq.size() == 0 && exp_f.size() == 0 && exp_d.size() == 0 &&
                gq.size() == 0 && !f_active && !d_active && !mem_req_o) break;
            n++;
        end
        if (n >= budget) fail_now({name, " did not drain within cycle budget"});
    endtask

    initial begin
        int d0;
        int n;
        rst_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'hBAD0_0000;
        checks = 0; errors = 0; f_done_cnt = 0; d_done_cnt = 0;
        f_active = 0; d_active = 0; in_txn = 0;
        stall_if_cnt = 0; stall_mem_cnt = 0; req_cyc = 0;
        cur = '{we: 1'b0, addr: '0, wdata: '0};
        fork
            monitor_loop();
            fetch_req_loop();
            data_req_loop();
            resp_loop();
        join_none

        // Reset values
        #3;
        chk32("rst mem_req", {31'b0, mem_req_o}, 32'd0);
        chk32("rst mem_we", {31'b0, mem_we_o}, 32'd0);
        chk32("rst mem_addr", mem_addr_o, 32'd0);
        chk32("rst mem_wdata", mem_wdata_o, 32'd0);
        chk32("rst timeout", {31'b0, timeout_o}, 32'd0);
        chk32("rst valids", {30'b0, if_valid_o, d_valid_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);

        // Fetch only: 3 wait cycles, ack on the 4th FETCH cycle
        stall_if_cnt = 0;
        expect_grant(1'b0, 32'h10, 32'h0);
        respond(3, 32'h0050_0093);
        issue_fetch(32'h10, 32'h0050_0093);
        wait_idle(50, "fetch only");
        chk32("stall_if cycles", stall_if_cnt, 32'd4);

        // Simultaneous and alternating: D, F, D, F
        expect_grant(1'b0, 32'h100, 32'h0);
        expect_grant(1'b0, 32'h40, 32'h0);
        expect_grant(1'b0, 32'h104, 32'h0);
        expect_grant(1'b0, 32'h44, 32'h0);
        respond(0, 32'h1111_1111);
        respond(1, 32'h3333_3333);
        respond(0, 32'h2222_2222);
        respond(2, 32'h4444_4444);
        issue_fetch(32'h40, 32'h3333_3333);
        issue_fetch(32'h44, 32'h4444_4444);
        issue_data(1'b0, 32'h100, 32'h0, 32'h1111_1111, 1'b1);
        issue_data(1'b0, 32'h104, 32'h0, 32'h2222_2222, 1'b1);
        wait_idle(80, "alternation");

        // Store: 2 wait cycles
        stall_mem_cnt = 0;
        expect_grant(1'b1, 32'h20, 32'hDEAD_BEEF);
        respond(2, 32'h0);
        issue_data(1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
        wait_idle(50, "store");
        chk32("stall_mem cycles", stall_mem_cnt, 32'd3);

        // Reset in the middle of a load; the request stays up and is re-granted
        expect_grant(1'b0, 32'h30, 32'h0);
        expect_grant(1'b0, 32'h30, 32'h0);
        respond(4, 32'h0000_0055);
        issue_data(1'b0, 32'h30, 32'h0, 32'h0000_0055, 1'b1);
        n = 0;
        while (!mem_req_o && n < 20) begin
            @(posedge clk_i);
            #3;
            n++;
        end
        if (n >= 20) fail_now("reset test grant never seen");
        d0 = d_done_cnt;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        chk32("midrst mem_req", {31'b0, mem_req_o}, 32'd0);
        chk32("midrst mem_addr", mem_addr_o, 32'd0);
        chk32("midrst d_valid", {31'b0, d_valid_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        #2 respond(1, 32'h0000_0055);
        wait_idle(50, "reset re-grant");
        chk32("d completions after reset", d_done_cnt, d0 + 1);

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: 15 wait cycles then a NOP completion and sticky timeout
        req_cyc = 0;
        expect_grant(1'b0, 32'h80, 32'h0);
        issue_fetch(32'h80, 32'h0000_0013);
        wait_idle(60, "timeout");
        chk32("timeout req cycles", req_cyc, 32'd15);
        chk32("timeout flag", {31'b0, timeout_o}, 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk32("timeout sticky", {31'b0, timeout_o}, 32'd1);
`else
        chk32("timeout tied low", {31'b0, timeout_o}, 32'd0);
`endif
        chk32("final mem_req", {31'b0, mem_req_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
